// File: rtl/seq_stim_gen_if.sv
// Handshake and serial-line bundle between a word source and seq_stim_gen.
// The master side supplies words and clears; the slave side is the generator.
interface seq_stim_gen_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             cnt_clr;
    logic             seq;
    logic             seq_valid;
    logic             word_done;
    logic             exp_out;
    logic [15:0]      match_count;

    modport master (
        output in_valid, in_data, cnt_clr,
        input  in_ready, seq, seq_valid, word_done, exp_out, match_count
    );

    modport slave (
        input  in_valid, in_data, cnt_clr,
        output in_ready, seq, seq_valid, word_done, exp_out, match_count
    );
endinterface

// File: rtl/seq_stim_gen.sv
// MSB-first serializer driving a "010" detector's input line, with a golden
// Mealy model of that detector and a saturating match counter.
module seq_stim_gen #(
    parameter int   WIDTH      = 8,
    parameter int   OVERLAP    = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input logic          clk,
    input logic          rst,
    seq_stim_gen_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} ser_t;
    typedef enum logic [1:0] {S0, S1, S2} mdl_t;

    ser_t             ser_q, ser_d;
    mdl_t             mdl_q, mdl_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic             seq_q, seq_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             last, accept, exp_out;

    assign last          = (bit_cnt_q == '0);
    assign bus.in_ready  = (ser_q == IDLE) || last;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.seq       = seq_q;
    assign bus.seq_valid = (ser_q == SHIFT);
    assign bus.word_done = (ser_q == SHIFT) && last;
    // Mealy output: depends on the bit currently on the line
    assign exp_out         = (mdl_q == S2) && !seq_q;
    assign bus.exp_out     = exp_out;
    assign bus.match_count = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_q     <= IDLE;
            mdl_q     <= S0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            seq_q     <= IDLE_LEVEL;
            cnt_q     <= '0;
        end else begin
            ser_q     <= ser_d;
            mdl_q     <= mdl_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ser_d     = ser_q;
        seq_d     = seq_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        // an accept in the last-bit cycle takes priority over going idle
        if (accept) begin
            seq_d     = bus.in_data[WIDTH-1];
            sh_d      = bus.in_data[WIDTH-2:0];
            bit_cnt_d = CW'(WIDTH - 1);
            ser_d     = SHIFT;
        end else if (ser_q == SHIFT) begin
            if (!last) begin
                seq_d     = sh_q[WIDTH-2];
                sh_d      = sh_q << 1;
                bit_cnt_d = bit_cnt_q - CW'(1);
            end else begin
                seq_d = IDLE_LEVEL;
                ser_d = IDLE;
            end
        end
    end

    // The detector samples every cycle, so idle fill advances the model too
    always_comb begin
        mdl_d = mdl_q;
        case (mdl_q)
            S0:      mdl_d = seq_q ? S0 : S1;
            S1:      mdl_d = seq_q ? S2 : S1;
            S2:      mdl_d = seq_q ? S0 : ((OVERLAP != 0) ? S1 : S0);
            default: mdl_d = S0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr)
            cnt_d = '0;
        else if (exp_out && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end
endmodule

// File: tb/tb_seq_stim_gen.sv
// Drives two generators (OVERLAP=1 and OVERLAP=0) with the same stimulus and
// checks them every cycle against a bit-queue / sliding-window reference.
module tb_seq_stim_gen;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, cnt_clr;
    logic [W-1:0] in_data;

    always #5 clk = ~clk;

    seq_stim_gen_if #(.WIDTH(W)) ifc1 ();
    seq_stim_gen_if #(.WIDTH(W)) ifc0 ();

    assign ifc1.in_valid = in_valid;
    assign ifc1.in_data  = in_data;
    assign ifc1.cnt_clr  = cnt_clr;
    assign ifc0.in_valid = in_valid;
    assign ifc0.in_data  = in_data;
    assign ifc0.cnt_clr  = cnt_clr;

    seq_stim_gen #(.WIDTH(W), .OVERLAP(1), .IDLE_LEVEL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    seq_stim_gen #(.WIDTH(W), .OVERLAP(0), .IDLE_LEVEL(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(ifc0.slave));

    int checks = 0;
    int errors = 0;

    // Reference: q holds the bits still to appear on seq (q[0] is on the line
    // now); h1/h2 are the previous two line values; p1/p2 flag matches there.
    bit          q[$];
    bit          h1, h2;
    bit          p1[2], p2[2];
    logic [15:0] m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic bit m_seq();
        return (q.size() > 0) ? q[0] : 1'b1;
    endfunction

    // k=1: overlapping detector, k=0: restart after each match
    function automatic bit m_exp(input int k);
        bit hit;
        hit = !h2 && h1 && !m_seq();
        return (k == 1) ? hit : (hit && !p2[0]);
    endfunction

    task automatic m_reset();
        q.delete();
        h1 = 1'b1;
        h2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            p1[k] = 1'b0; p2[k] = 1'b0; m_cnt[k] = 16'd0;
        end
    endtask

    task automatic m_step();
        bit e[2];
        bit rdy;
        bit cur;
        rdy = (q.size() <= 1);
        cur = m_seq();
        for (int k = 0; k < 2; k++) e[k] = m_exp(k);
        for (int k = 0; k < 2; k++) begin
            if (cnt_clr)                            m_cnt[k] = 16'd0;
            else if (e[k] && m_cnt[k] != 16'hFFFF)  m_cnt[k] = m_cnt[k] + 16'd1;
            p2[k] = p1[k];
            p1[k] = e[k];
        end
        h2 = h1;
        h1 = cur;
        if (q.size() > 0) void'(q.pop_front());
        if (in_valid && rdy)
            for (int i = W - 1; i >= 0; i--) q.push_back(in_data[i]);
    endtask

    task automatic tick();
        @(negedge clk);
        chk("seq",       ifc1.seq,         m_seq());
        chk("seq_nov",   ifc0.seq,         m_seq());
        chk("seq_valid", ifc1.seq_valid,   q.size() > 0);
        chk("in_ready",  ifc1.in_ready,    q.size() <= 1);
        chk("word_done", ifc1.word_done,   q.size() == 1);
        chk("exp_ov",    ifc1.exp_out,     m_exp(1));
        chk("exp_nov",   ifc0.exp_out,     m_exp(0));
        chk("cnt_ov",    ifc1.match_count, m_cnt[1]);
        chk("cnt_nov",   ifc0.match_count, m_cnt[0]);
        @(posedge clk);
        if (rst) m_reset();
        else     m_step();
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input bit hold);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = (q.size() <= 1);
            tick();
        end
        chk("accept", acc, 1);
        if (!hold) in_valid = 1'b0;
        in_data = W'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seq"},   ifc1.seq,         1);
        chk({tag, "_sv"},    ifc1.seq_valid,   0);
        chk({tag, "_rdy"},   ifc1.in_ready,    1);
        chk({tag, "_wd"},    ifc1.word_done,   0);
        chk({tag, "_exp"},   ifc1.exp_out,     0);
        chk({tag, "_cnt1"},  ifc1.match_count, 0);
        chk({tag, "_cnt0"},  ifc0.match_count, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; in_data = '0;
        m_reset();
        #2 chk_reset_vals("reset");
        tick(); tick();
        rst = 1'b0;

        // single 0x52: 3 matches overlapping, 2 without
        send(8'h52, 1'b0); idle(10);
        chk("m52_ov", ifc1.match_count, 3);
        chk("m52_nov", ifc0.match_count, 2);

        // back-to-back 0x52 pair
        clr(); send(8'h52, 1'b1); send(8'h52, 1'b0); idle(10);
        chk("b2b_ov", ifc1.match_count, 6);

        // cross-boundary match, then the same with one idle bit in between
        clr(); send(8'h01, 1'b0); send(8'h00, 1'b0); idle(10);
        chk("xb_gapless", ifc1.match_count, 1);
        clr(); send(8'h01, 1'b0); idle(8); send(8'h00, 1'b0); idle(10);
        chk("xb_gap", ifc1.match_count, 0);

        clr(); send(8'hFF, 1'b0); send(8'h00, 1'b0); idle(10);
        chk("ff00", ifc1.match_count, 0);

        // asynchronous reset on the 4th bit of a word
        clr(); send(8'h52, 1'b0); tick(); tick(); tick();
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        m_reset();
        tick();
        rst = 1'b0;
        send(8'h52, 1'b0); idle(10);
        chk("after_rst", ifc1.match_count, 3);

        // saturation: preload near the top, then run two words
        force dut1.cnt_q = 16'hFFFD;
        force dut0.cnt_q = 16'hFFFD;
        #1;
        release dut1.cnt_q;
        release dut0.cnt_q;
        m_cnt[1] = 16'hFFFD;
        m_cnt[0] = 16'hFFFD;
        send(8'h52, 1'b1); send(8'h52, 1'b0); idle(10);
        chk("sat_ov", ifc1.match_count, 16'hFFFF);
        chk("sat_nov", ifc0.match_count, 16'hFFFF);

        // clear in a cycle where a match is reported
        send(8'h52, 1'b0);
        for (int n = 0; n < 12; n++) begin
            if (m_exp(1)) begin
                clr();
                chk("clr_on_match", ifc1.match_count, 0);
                break;
            end
            tick();
        end
        idle(10);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            cnt_clr  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 0) in_data = W'($urandom_range(0, 1) ? 8'h52 : 8'h25);
            tick();
        end
        cnt_clr = 1'b0;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
